// File: rtl/echo_ram_drain.sv
// Drains each captured echo frame from the 128x25 capture RAM onto an AXI4-Stream master.
// Define ECHO_DRAIN_HDR_EN to prepend a {A5, seq, 00, count} header beat to every frame.
module echo_ram_drain #(
  parameter int DATA_W = 25,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sending,
  output logic [ADDR_W-1:0] read_add,
  output logic              rd_en,
  input  logic [DATA_W-1:0] read_data,
  output logic [OUT_W-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              ovr
);
  localparam int CW = ADDR_W + 1;

`ifdef ECHO_DRAIN_HDR_EN
  typedef enum logic [2:0] {IDLE = 3'd0, CAPT = 3'd1, HDR = 3'd2, RD = 3'd3,
                            WAIT = 3'd4, SEND = 3'd5} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, CAPT = 3'd1, RD = 3'd3,
                            WAIT = 3'd4, SEND = 3'd5} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0]  tdata_d;
  logic              tvalid_d, tlast_d, ovr_d;
  logic              sending_q;
  logic              ign_q, ign_d;
  logic              sat_q, sat_d;
  logic              drain;
`ifdef ECHO_DRAIN_HDR_EN
  logic [7:0]        seq_q, seq_d;
`endif

  assign read_add = idx_q;
  assign rd_en    = (state_q == RD);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      ovr       <= 1'b0;
      sending_q <= 1'b0;
      ign_q     <= 1'b0;
      sat_q     <= 1'b0;
`ifdef ECHO_DRAIN_HDR_EN
      seq_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      m_tdata   <= tdata_d;
      m_tvalid  <= tvalid_d;
      m_tlast   <= tlast_d;
      ovr       <= ovr_d;
      sending_q <= sending;
      ign_q     <= ign_d;
      sat_q     <= sat_d;
`ifdef ECHO_DRAIN_HDR_EN
      seq_q     <= seq_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tdata_d  = m_tdata;
    tvalid_d = m_tvalid;
    tlast_d  = m_tlast;
    ovr_d    = 1'b0;
    sat_d    = sat_q;
`ifdef ECHO_DRAIN_HDR_EN
    seq_d    = seq_q;
`endif
    drain    = (state_q != IDLE) && (state_q != CAPT);
    // A new write burst while draining clobbers the RAM: flag it, then lock out until sending drops.
    if (drain && sending && !sending_q) ovr_d = 1'b1;
    ign_d = ign_q;
    if (!sending) ign_d = 1'b0;
    else if (drain) ign_d = 1'b1;

    case (state_q)
      IDLE: if (sending && !ign_q) begin
        state_d = CAPT;
        cnt_d   = CW'(1);
        sat_d   = 1'b0;
      end
      CAPT: begin
        if (sending) begin
          if (cnt_q < CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
          else if (!sat_q) begin
            ovr_d = 1'b1;
            sat_d = 1'b1;
          end
        end else begin
          idx_d = '0;
`ifdef ECHO_DRAIN_HDR_EN
          state_d  = HDR;
          tdata_d  = OUT_W'({8'hA5, seq_q, 8'h00, 8'(cnt_q)});
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
`else
          state_d = RD;
`endif
        end
      end
`ifdef ECHO_DRAIN_HDR_EN
      HDR: if (m_tready) begin
        tvalid_d = 1'b0;
        state_d  = RD;
      end
`endif
      RD: state_d = WAIT;
      WAIT: begin
        tdata_d  = OUT_W'(read_data);
        tvalid_d = 1'b1;
        tlast_d  = ({1'b0, idx_q} == cnt_q - CW'(1));
        state_d  = SEND;
      end
      SEND: if (m_tready) begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (m_tlast) begin
          // sending high on the first IDLE cycle must not start a frame
          ign_d   = 1'b1;
          state_d = IDLE;
`ifdef ECHO_DRAIN_HDR_EN
          seq_d   = seq_q + 8'd1;
`endif
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_echo_ram_drain.sv
// Scoreboard bench for echo_ram_drain: stimulus pushes expected beats, a monitor pops on each handshake.
module tb_echo_ram_drain;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sending = 1'b0;
  logic [6:0]  read_add;
  logic        rd_en;
  logic [24:0] read_data = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        busy;
  logic        ovr;

  logic [24:0] mem [128];
  logic [32:0] expq [$];
  int tests = 0, fails = 0;
  int hs_cnt = 0, ovr_cnt = 0;
  int last_rd_add = -1;
  logic [7:0] tb_seq = 8'd0;

  echo_ram_drain dut (
    .clk(clk), .rst(rst), .sending(sending), .read_add(read_add), .rd_en(rd_en),
    .read_data(read_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) read_data <= mem[read_add];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshake checking, stall stability, rd_en exclusivity, ovr counting.
  initial begin
    logic        stalled = 1'b0;
    logic [32:0] held = '0;
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ovr) ovr_cnt++;
        if (rd_en) begin
          last_rd_add = int'(read_add);
          chk("rd_en_while_valid", {32'd0, m_tvalid}, 33'd0);
        end
        if (stalled) chk("stall_stable", {m_tvalid, m_tlast, m_tdata[30:0]}, {1'b1, held[32], held[30:0]});
        if (m_tvalid && m_tready) begin
          hs_cnt++;
          if (expq.size() == 0) chk("unexpected_beat", {m_tlast, m_tdata}, 33'h1_DEAD_BEEF);
          else begin
            exp = expq.pop_front();
            chk("beat", {m_tlast, m_tdata}, exp);
          end
        end
        stalled = m_tvalid && !m_tready;
        held = {m_tlast, m_tdata};
      end else stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_frame(input int n);
`ifdef ECHO_DRAIN_HDR_EN
    expq.push_back({1'b0, 8'hA5, tb_seq, 8'h00, 8'(n)});
`endif
    for (int i = 0; i < n; i++) expq.push_back({(i == n - 1), 32'(mem[i])});
    tb_seq = tb_seq + 8'd1;
  endtask

  task automatic drive_sending(input int n);
    sending = 1'b1;
    repeat (n) tick();
    sending = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || expq.size() != 0) && k < 3000) begin tick(); k++; end
    repeat (4) tick();
    chk({name, "_drained"}, 33'(expq.size()), 33'd0);
    chk({name, "_busy"}, {32'd0, busy}, 33'd0);
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_cnt < target && k < 500) begin tick(); k++; end
    chk("wait_hs", 33'(hs_cnt >= target), 33'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_read_add"}, 33'(read_add), 33'd0);
    chk({name, "_rd_en"},    33'(rd_en),    33'd0);
    chk({name, "_tdata"},    33'(m_tdata),  33'd0);
    chk({name, "_tvalid"},   33'(m_tvalid), 33'd0);
    chk({name, "_tlast"},    33'(m_tlast),  33'd0);
    chk({name, "_busy"},     33'(busy),     33'd0);
    chk({name, "_ovr"},      33'(ovr),      33'd0);
  endtask

  initial begin
    int b0, o0, k;
    for (int i = 0; i < 128; i++) mem[i] = 25'(32'h0100_0000 | (i * 3 + 7));
    #12;
    chk_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    // 1: basic 4-word frame
    mem[0] = 25'h11; mem[1] = 25'h22; mem[2] = 25'h33; mem[3] = 25'h44;
    m_tready = 1'b1;
    b0 = hs_cnt; o0 = ovr_cnt;
    push_frame(4);
    drive_sending(4);
    wait_idle("basic");
`ifdef ECHO_DRAIN_HDR_EN
    chk("basic_beats", 33'(hs_cnt - b0), 33'd5);
`else
    chk("basic_beats", 33'(hs_cnt - b0), 33'd4);
`endif
    chk("basic_ovr", 33'(ovr_cnt - o0), 33'd0);

    // 2: back-pressure stall on beat 2
    b0 = hs_cnt;
    push_frame(4);
    drive_sending(4);
`ifdef ECHO_DRAIN_HDR_EN
    wait_hs(b0 + 2);
`else
    wait_hs(b0 + 1);
`endif
    m_tready = 1'b0;
    repeat (5) tick();
    m_tready = 1'b1;
    wait_idle("stall");

    // 3: 130-cycle burst saturates at 128 words
    b0 = hs_cnt; o0 = ovr_cnt;
    for (int i = 0; i < 128; i++) mem[i] = 25'(32'h0100_0000 | (i * 3 + 7));
    push_frame(128);
    drive_sending(130);
    wait_idle("full");
    chk("full_ovr", 33'(ovr_cnt - o0), 33'd1);
    chk("full_last_addr", 33'(last_rd_add), 33'd127);
`ifdef ECHO_DRAIN_HDR_EN
    chk("full_beats", 33'(hs_cnt - b0), 33'd129);
`else
    chk("full_beats", 33'(hs_cnt - b0), 33'd128);
`endif

    // 4: single-word frame
    mem[0] = 25'h1ABCDEF;
    b0 = hs_cnt;
    push_frame(1);
    drive_sending(1);
    wait_idle("single");
    chk("single_addr", 33'(last_rd_add), 33'd0);

    // 5: overlapping burst during beat 1 is flagged and dropped
    mem[0] = 25'h0A; mem[1] = 25'h0B; mem[2] = 25'h0C;
    b0 = hs_cnt; o0 = ovr_cnt;
    m_tready = 1'b0;
    push_frame(3);
    drive_sending(3);
`ifdef ECHO_DRAIN_HDR_EN
    m_tready = 1'b1;
    wait_hs(b0 + 1);
    m_tready = 1'b0;
`endif
    k = 0;
    while (!m_tvalid && k < 50) begin tick(); k++; end
    chk("overlap_valid_seen", 33'(m_tvalid), 33'd1);
    drive_sending(2);
    m_tready = 1'b1;
    wait_idle("overlap");
    chk("overlap_ovr", 33'(ovr_cnt - o0), 33'd1);
`ifdef ECHO_DRAIN_HDR_EN
    chk("overlap_beats", 33'(hs_cnt - b0), 33'd4);
`else
    chk("overlap_beats", 33'(hs_cnt - b0), 33'd3);
`endif

    // 6: reset mid-frame, then a clean 2-word frame
    mem[0] = 25'h55; mem[1] = 25'h66; mem[2] = 25'h77; mem[3] = 25'h88;
    b0 = hs_cnt;
    push_frame(4);
    drive_sending(4);
`ifdef ECHO_DRAIN_HDR_EN
    wait_hs(b0 + 2);
`else
    wait_hs(b0 + 1);
`endif
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    expq.delete();
    tb_seq = 8'd0;
    tick();
    rst = 1'b0;
    tick();
    mem[0] = 25'h1234567; mem[1] = 25'h0FEDCBA;
    b0 = hs_cnt;
    push_frame(2);
    drive_sending(2);
    wait_idle("after_rst");
`ifdef ECHO_DRAIN_HDR_EN
    chk("after_rst_beats", 33'(hs_cnt - b0), 33'd3);
`else
    chk("after_rst_beats", 33'(hs_cnt - b0), 33'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
